// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample sequencer and the FIR engine it drives.
package fir_pkg;

  // Default widths shared with the 8-tap, 8-bit-coefficient engine.
  localparam int FIR_DW = 8;
  localparam int FIR_CW = 8;
  localparam int FIR_K  = 8;
  localparam int FIR_YW = FIR_DW + FIR_CW + $clog2(FIR_K) + 1;

  // Sequencer states. The encoding is fixed so it can be read from debug taps.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  // Pointer width for a power-of-two FIFO. Never returns 0.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Bundles the sample input, engine handshake, result port and status lines
// of the sequencer. slave = sequencer side, master = surrounding system side.
interface fir_sample_sequencer_if
  import fir_pkg::*;
#(
  parameter int DW = FIR_DW,
  parameter int YW = FIR_YW
);

  logic                 enable;
  logic                 clear;
  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 s_ready;
  logic                 eng_start;
  logic signed [DW-1:0] eng_x;
  logic                 eng_valid;
  logic signed [YW-1:0] eng_y;
  logic                 y_valid;
  logic signed [YW-1:0] y_data;
  logic                 y_ready;
  logic                 busy;
  logic                 err_timeout;
  logic                 err_spurious;

  modport slave (
    input  enable, clear, s_valid, s_data, eng_valid, eng_y, y_ready,
    output s_ready, eng_start, eng_x, y_valid, y_data, busy,
           err_timeout, err_spurious
  );

  modport master (
    output enable, clear, s_valid, s_data, eng_valid, eng_y, y_ready,
    input  s_ready, eng_start, eng_x, y_valid, y_data, busy,
           err_timeout, err_spurious
  );

endinterface

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample FIFO with registered count and flags.
// Flush has priority over push and pop in the same cycle.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = fifo_ptr_w(DEPTH);
  localparam int NW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          wr_en, rd_en;

  assign wr_en   = push_i & ~full_q;
  assign rd_en   = pop_i & ~empty_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + NW'(wr_en) - NW'(rd_en);
    end
  end

  // Pointer, count and flag registers; flags are derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == NW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Front-end sequencer for the single-sample FIR engine: buffers samples,
// issues one engine start per sample, guards each computation with a
// watchdog and presents the result on a valid/ready port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no sample in flight; pops FIFO head when enabled
//   ST_ISSUE | eng_start high for this one cycle; watchdog loaded
//   ST_WAIT  | eng_x held, waiting for eng_valid or watchdog expiry
//   ST_HOLD  | result presented on y_*, waiting for the consumer
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int DW      = FIR_DW,
  parameter int YW      = FIR_YW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_sample_sequencer_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT);

  seq_state_t           state_q, state_d;
  logic signed [DW-1:0] eng_x_q, eng_x_d;
  logic signed [YW-1:0] y_data_q, y_data_d;
  logic                 y_valid_q, y_valid_d;
  logic [TW-1:0]        wdog_q, wdog_d;
  logic                 err_to_q, err_to_d;
  logic                 err_sp_q, err_sp_d;
  logic                 rdy_q;

  logic                 pop;
  logic                 push;
  logic                 eng_start;
  logic                 s_ready;
  logic [DW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  // s_ready stays low while in reset and for the first cycle after release.
  assign s_ready = rdy_q & ~fifo_full;
  // A clear in the same cycle discards the push even though s_ready is high.
  assign push    = bus.s_valid & s_ready & ~bus.clear;

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.s_data),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, datapath capture and error-flag logic.
  always_comb begin
    state_d   = state_q;
    eng_x_d   = eng_x_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    wdog_d    = wdog_q;
    err_to_d  = err_to_q & ~bus.clear;
    err_sp_d  = err_sp_q & ~bus.clear;
    pop       = 1'b0;
    eng_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable && !fifo_empty && !bus.clear) begin
          pop     = 1'b1;
          eng_x_d = fifo_dout;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        wdog_d    = TW'(TIMEOUT - 1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.eng_valid) begin
          y_data_d  = bus.eng_y;
          y_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (wdog_q == '0) begin
          // Engine never answered: drop this sample and move on.
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wdog_d = wdog_q - TW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error in the same cycle as clear is kept so it is not lost.
    if (bus.eng_valid && state_q != ST_WAIT) err_sp_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      eng_x_q   <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      wdog_q    <= '0;
      err_to_q  <= 1'b0;
      err_sp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      eng_x_q   <= eng_x_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      wdog_q    <= wdog_d;
      err_to_q  <= err_to_d;
      err_sp_q  <= err_sp_d;
    end
  end

  // Holds s_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  assign bus.s_ready      = s_ready;
  assign bus.eng_start    = eng_start;
  assign bus.eng_x        = eng_x_q;
  assign bus.y_valid      = y_valid_q;
  assign bus.y_data       = y_data_q;
  assign bus.busy         = (state_q != ST_IDLE) | ~fifo_empty;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_spurious = err_sp_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Self-checking bench for fir_sample_sequencer with a behavioural engine.
module tb_fir_sample_sequencer;
  import fir_pkg::*;

  localparam int DW      = FIR_DW;
  localparam int YW      = FIR_YW;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_sample_sequencer_if #(.DW(DW), .YW(YW)) bus ();

  fir_sample_sequencer #(
    .DW(DW), .YW(YW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  logic signed [YW-1:0] got_q[$];
  logic signed [YW-1:0] exp_q[$];
  bit   rnd_ready  = 1'b0;
  bit   eng_silent = 1'b0;
  logic spur = 1'b0;

  // Reference: the engine computes y = 3*x, passed through unchanged.
  function automatic logic signed [YW-1:0] model_y(input logic signed [DW-1:0] x);
    return YW'(3 * int'(x));
  endfunction

  // Behavioural engine: answers ENG_LAT cycles after start, or never if silent.
  logic                 eng_vm;
  logic                 eng_act;
  int                   eng_cnt;
  logic signed [DW-1:0] eng_xcap;
  logic signed [YW-1:0] eng_ym;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_vm   <= 1'b0;
      eng_act  <= 1'b0;
      eng_cnt  <= 0;
      eng_xcap <= '0;
      eng_ym   <= '0;
    end else begin
      eng_vm <= 1'b0;
      if (bus.eng_start) begin
        eng_act  <= !eng_silent;
        eng_cnt  <= ENG_LAT - 1;
        eng_xcap <= bus.eng_x;
      end else if (eng_act) begin
        if (eng_cnt == 0) begin
          eng_vm  <= 1'b1;
          eng_ym  <= model_y(eng_xcap);
          eng_act <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  assign bus.eng_valid = eng_vm | spur;
  assign bus.eng_y     = eng_ym;

  // Collects delivered results and counts engine starts.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.y_valid && bus.y_ready) got_q.push_back(bus.y_data);
      if (bus.eng_start) starts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.y_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_one(input logic signed [DW-1:0] x);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = x;
    while (!bus.s_ready && n < 2000) begin tick(); n++; end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL push_wait s_ready=%0b want=1", bus.s_ready);
    end else begin
      tick();
      exp_q.push_back(model_y(x));
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_y(output bit ok);
    int n = 0;
    while (!bus.y_valid && n < 300) begin tick(); n++; end
    ok = bus.y_valid;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin tick(); n++; end
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.clear = 1'b0; bus.s_valid = 1'b0;
    bus.s_data = '0;   bus.y_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.s_ready, bus.eng_start, bus.y_valid, bus.busy, bus.err_timeout, bus.err_spurious} !== 6'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000000", {bus.s_ready, bus.eng_start, bus.y_valid, bus.busy, bus.err_timeout, bus.err_spurious});
    end
    total++;
    if (bus.eng_x !== '0 || bus.y_data !== '0) begin
      bad++; $display("FAIL rst_data eng_x=%0d y_data=%0d want=0", bus.eng_x, bus.y_data);
    end
    #2 rst = 1'b0;
    tick(); tick();
    total++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rst_release s_ready=%0b busy=%0b want=1/0", bus.s_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    int n = 0;
    bit ok_x = 1'b1;
    wait_idle();
    bus.y_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'sd5;
    tick();
    bus.s_valid = 1'b0;
    total++;
    if (bus.eng_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%0b want=0", bus.eng_start); end
    tick();
    total++;
    if (bus.eng_start !== 1'b1 || bus.eng_x !== 8'sd5) begin
      bad++; $display("FAIL single_start eng_start=%0b eng_x=%0d want=1/5", bus.eng_start, bus.eng_x);
    end
    while (!bus.eng_valid && n < 40) begin
      if (bus.eng_x !== 8'sd5) ok_x = 1'b0;
      tick(); n++;
    end
    total++;
    if (n >= 40 || !ok_x) begin bad++; $display("FAIL single_hold_x cycles=%0d stable=%0b want=<40/1", n, ok_x); end
    tick();
    total++;
    if (bus.y_valid !== 1'b1 || bus.y_data !== model_y(8'sd5)) begin
      bad++; $display("FAIL single_result y_valid=%0b y_data=%0d want=1/%0d", bus.y_valid, bus.y_data, model_y(8'sd5));
    end
    tick();
    total++;
    if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_done y_valid=%0b busy=%0b want=0/0", bus.y_valid, bus.busy);
    end
  endtask

  task automatic test_burst();
    int gb, eb, n;
    wait_idle();
    gb = got_q.size(); eb = exp_q.size();
    bus.enable = 1'b0; bus.y_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_one(DW'(i + 1));
      total++;
      if (bus.s_ready !== ((i + 1) < DEPTH)) begin
        bad++; $display("FAIL burst_s_ready after %0d got=%0b want=%0b", i + 1, bus.s_ready, (i + 1) < DEPTH);
      end
    end
    bus.enable = 1'b1;
    push_one(8'sd5);
    push_one(8'sd6);
    n = 0;
    while (got_q.size() - gb < 6 && n < 600) begin tick(); n++; end
    total++;
    if (got_q.size() - gb != 6) begin bad++; $display("FAIL burst_count got=%0d want=6", got_q.size() - gb); end
    else for (int i = 0; i < 6; i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) begin
        bad++; $display("FAIL burst_data[%0d] got=%0d want=%0d", i, got_q[gb + i], exp_q[eb + i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stall_ok = 1'b1;
    int s0;
    wait_idle();
    bus.y_ready = 1'b0;
    push_one(8'sd1);
    push_one(8'sd2);
    wait_y(ok);
    total++;
    if (!ok || bus.y_data !== model_y(8'sd1)) begin
      bad++; $display("FAIL stall_first ok=%0b y_data=%0d want=1/%0d", ok, bus.y_data, model_y(8'sd1));
    end
    s0 = starts;
    repeat (30) begin
      if (!bus.y_valid || bus.y_data !== model_y(8'sd1) || bus.eng_start) stall_ok = 1'b0;
      tick();
    end
    total++;
    if (!stall_ok || starts != s0) begin
      bad++; $display("FAIL stall_hold held=%0b starts=%0d want=1/%0d", stall_ok, starts, s0);
    end
    bus.y_ready = 1'b1;
    tick();
    total++;
    if (bus.eng_start !== 1'b0) begin bad++; $display("FAIL stall_start_early got=%0b want=0", bus.eng_start); end
    tick();
    total++;
    if (bus.eng_start !== 1'b1 || bus.eng_x !== 8'sd2) begin
      bad++; $display("FAIL stall_next eng_start=%0b eng_x=%0d want=1/2", bus.eng_start, bus.eng_x);
    end
    wait_y(ok);
    total++;
    if (!ok || bus.y_data !== model_y(8'sd2)) begin
      bad++; $display("FAIL stall_second ok=%0b y_data=%0d want=1/%0d", ok, bus.y_data, model_y(8'sd2));
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok;
    wait_idle();
    bus.y_ready = 1'b1;
    eng_silent  = 1'b1;
    push_one(8'sd7);
    push_one(8'sd8);
    while (!bus.eng_start && n < 50) begin tick(); n++; end
    total++;
    if (bus.eng_x !== 8'sd7) begin bad++; $display("FAIL to_issue eng_x=%0d want=7", bus.eng_x); end
    tick();
    n = 0;
    while (!bus.err_timeout && n < 200) begin tick(); n++; end
    eng_silent = 1'b0;
    total++;
    if (n != TIMEOUT) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", n, TIMEOUT); end
    total++;
    if (bus.busy !== 1'b1 || bus.y_valid !== 1'b0) begin
      bad++; $display("FAIL to_after busy=%0b y_valid=%0b want=1/0", bus.busy, bus.y_valid);
    end
    tick();
    total++;
    if (bus.eng_start !== 1'b1 || bus.eng_x !== 8'sd8) begin
      bad++; $display("FAIL to_next eng_start=%0b eng_x=%0d want=1/8", bus.eng_start, bus.eng_x);
    end
    wait_y(ok);
    total++;
    if (!ok || bus.y_data !== model_y(8'sd8)) begin
      bad++; $display("FAIL to_result ok=%0b y_data=%0d want=1/%0d", ok, bus.y_data, model_y(8'sd8));
    end
    tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    total++;
    if (bus.err_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b want=0", bus.err_timeout); end
  endtask

  task automatic test_spurious_clear();
    bit ok;
    int s0;
    logic signed [DW-1:0] x;
    wait_idle();
    x = DW'($urandom);
    bus.y_ready = 1'b1; bus.enable = 1'b1;
    push_one(x);
    wait_y(ok);
    tick();
    wait_idle();
    spur = 1'b1; tick(); spur = 1'b0;
    total++;
    if (!ok || bus.err_spurious !== 1'b1 || bus.y_valid !== 1'b0 || bus.y_data !== model_y(x)) begin
      bad++; $display("FAIL spurious err=%0b y_valid=%0b y_data=%0d want=1/0/%0d", bus.err_spurious, bus.y_valid, bus.y_data, model_y(x));
    end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    total++;
    if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL spurious_clear got=%0b want=0", bus.err_spurious); end

    bus.enable = 1'b0;
    push_one(8'sd11); push_one(8'sd12); push_one(8'sd13);
    total++;
    if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      bad++; $display("FAIL clear_queued busy=%0b s_ready=%0b want=1/1", bus.busy, bus.s_ready);
    end
    s0 = starts;
    bus.clear = 1'b1; bus.enable = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (20) tick();
    total++;
    if (starts != s0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL clear_flush starts=%0d busy=%0b want=%0d/0", starts, bus.busy, s0);
    end
    bus.s_valid = 1'b1; bus.s_data = 8'sd55; bus.clear = 1'b1;
    #1;
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL clear_push_ready got=%0b want=1", bus.s_ready); end
    tick();
    bus.s_valid = 1'b0; bus.clear = 1'b0;
    repeat (10) tick();
    total++;
    if (starts != s0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL clear_push_drop starts=%0d busy=%0b want=%0d/0", starts, bus.busy, s0);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    bit ok;
    wait_idle();
    bus.enable = 1'b1; bus.y_ready = 1'b1;
    push_one(8'sd9);
    while (!bus.eng_start && n < 50) begin tick(); n++; end
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.s_ready, bus.eng_start, bus.y_valid, bus.busy, bus.err_timeout, bus.err_spurious} !== 6'b0 ||
        bus.eng_x !== '0 || bus.y_data !== '0) begin
      bad++; $display("FAIL arst_outputs flags=%b eng_x=%0d y_data=%0d want=0", {bus.s_ready, bus.eng_start, bus.y_valid, bus.busy, bus.err_timeout, bus.err_spurious}, bus.eng_x, bus.y_data);
    end
    #3 rst = 1'b0;
    tick(); tick();
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b want=1", bus.s_ready); end
    push_one(-8'sd10);
    wait_y(ok);
    total++;
    if (!ok || bus.y_data !== model_y(-8'sd10)) begin
      bad++; $display("FAIL arst_next ok=%0b y_data=%0d want=1/%0d", ok, bus.y_data, model_y(-8'sd10));
    end
    tick();
  endtask

  task automatic test_random();
    int gb, eb, n;
    wait_idle();
    gb = got_q.size(); eb = exp_q.size();
    bus.enable = 1'b1;
    rnd_ready  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_one(DW'($urandom));
    end
    n = 0;
    while (got_q.size() - gb < 12 && n < 2000) begin tick(); n++; end
    rnd_ready   = 1'b0;
    bus.y_ready = 1'b1;
    total++;
    if (got_q.size() - gb != 12) begin bad++; $display("FAIL rand_count got=%0d want=12", got_q.size() - gb); end
    else for (int i = 0; i < 12; i++) begin
      total++;
      if (got_q[gb + i] !== exp_q[eb + i]) begin
        bad++; $display("FAIL rand_data[%0d] got=%0d want=%0d", i, got_q[gb + i], exp_q[eb + i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_timeout();
    test_spurious_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t want=finish", $time);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
- Front-end controller that sequences the single-sample FIR engine (start / data_valid / y interface).
- Buffers incoming samples in a small FIFO and issues one engine start per sample.
- Holds `eng_x` stable for the whole computation and returns each result over a valid/ready port with backpressure.
- Sits between the sample source and the FIR engine. Adds a watchdog and sticky error flags.

Parameters:
- DW, 8, input sample width.
- YW, 20, engine result width (DW+CW+clog2(K)+1 for the 8/8/8 engine).
- DEPTH, 4, sample FIFO depth; power of 2, ≥2.
- TIMEOUT, 64, max cycles in WAIT before abort; ≥16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = allow new engine starts; 0 = pause after the current sample
- clear  in  1  synchronous pulse: clears error flags and flushes the FIFO
- s_valid  in  1  input sample valid
- s_data  in  DW  input sample, signed
- s_ready  out  1  FIFO not full
- eng_start  out  1  one-cycle start pulse to the engine
- eng_x  out  DW  sample to the engine, registered
- eng_valid  in  1  engine result valid (one-cycle pulse)
- eng_y  in  YW  engine result, signed
- y_valid  out  1  result held for the consumer
- y_data  out  YW  result, registered
- y_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE or FIFO not empty
- err_timeout  out  1  sticky: watchdog expired
- err_spurious  out  1  sticky: eng_valid seen outside WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; s_ready=1 once reset is released.
- FIFO
  - Write on s_valid & s_ready. s_ready = !full, registered from the count.
  - Pop only in IDLE.
  - Simultaneous push and pop when full is not possible (s_ready=0); when empty, pop is blocked.
  - Pointers wrap mod DEPTH.
- IDLE
  - If enable & !empty & !clear: pop the head into eng_x, go to ISSUE.
- ISSUE
  - eng_start=1 for exactly this cycle.
  - Go to WAIT; clear the watchdog counter.
- WAIT
  - eng_x is held constant from the pop until leaving WAIT.
  - On eng_valid: y_data<=eng_y, y_valid<=1, go to HOLD.
  - Else increment the counter. When it reaches TIMEOUT-1: err_timeout<=1, drop the sample, go to IDLE.
- HOLD
  - y_valid stays high and y_data stable until y_valid & y_ready.
  - On that edge: y_valid<=0, go to IDLE. The next start can issue no earlier than the following cycle.
  - No engine start occurs while a result is unaccepted.
- Latency
  - Sample accepted at edge t into an empty FIFO with IDLE & enable: pop at t+1, eng_start high in cycle t+2.
  - y_valid rises on the edge after eng_valid.
  - Throughput: one sample per (engine latency + 3 + consumer stall) cycles.
- Spurious eng_valid: eng_valid in IDLE/ISSUE/HOLD sets err_spurious and is otherwise ignored; y_data is not modified.
- clear
  - Flushes the FIFO and clears both error flags.
  - Does not abort an in-flight WAIT/HOLD.
  - If clear and a push occur in the same cycle, clear wins and the push is discarded. s_ready is still 1 that cycle; this is documented.
- enable=0: current sample completes normally; FIFO keeps accepting until full.
- Async reset mid-operation: immediate return to reset values; in-flight result lost. The engine must be reset by the same rst.
- Arithmetic: eng_y passes through unmodified, signed, no width change.

Decomposition:
- Shared package (fir_pkg): state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, HOLD=3) and the default widths DW/CW/K/YW shared with the engine.
- One sub-module: fir_sample_fifo
  - Parameters DW, DEPTH.
  - Ports: push, pop, din, dout, full, empty, flush.
  - Synchronous, registered count, first-word-fall-through.
- Sequencer FSM, watchdog and output register live in fir_sample_sequencer.

Test Plan:
- Single sample.
  - Stimulus: engine model with 12-cycle latency returning y=3*x; push s_data=5 at edge t.
  - Required: eng_start high in cycle t+2; eng_x=5 stable until eng_valid; y_valid with y_data=15; busy drops after y_ready.
- Burst and backpressure.
  - Stimulus: push 6 samples 1..6 back-to-back with DEPTH=4.
  - Required: s_ready deasserts after the 4th buffered word; outputs 3,6,9,12,15,18 in order, none lost.
- Consumer stall.
  - Stimulus: y_ready=0 for 30 cycles after the first result.
  - Required: y_data=3 held; no eng_start during the stall; the next start comes after the handshake.
- Timeout.
  - Stimulus: engine never answers, TIMEOUT=64.
  - Required: err_timeout=1 exactly 64 cycles after WAIT entry; state IDLE; the next queued sample is issued.
  - Then pulse clear: err_timeout=0.
- Spurious and clear.
  - Stimulus: inject eng_valid while IDLE.
  - Required: err_spurious=1 and y_valid stays 0.
  - Stimulus: with 3 samples queued, pulse clear and enable=1.
  - Required: FIFO empty, no further eng_start.
- Async reset mid-WAIT.
  - Stimulus: assert rst in WAIT.
  - Required: all outputs 0 immediately, s_ready=1 after release; the next sample is processed normally.
